// File: rtl/tick_period_monitor.sv
`default_nettype none
// ============================================================================
// Module     : tick_period_monitor
// Description: Measures Pixelclock cycles between tick strobes, reports each
//              period and asserts locked after LOCK_COUNT consecutive periods
//              equal to EXPECTED. Define PERIOD_MINMAX_EN to add
//              min_period/max_period tracking.
// Revision   : 1.0  initial release
// ============================================================================
module tick_period_monitor #(
  parameter int unsigned EXPECTED   = 6250,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             Pixelclock,
  input  logic             reset,
  input  logic             tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             locked
`ifdef PERIOD_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
`endif
);

  localparam logic [0:0]       IDLE      = 1'b0;
  localparam logic [0:0]       MEASURE   = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXPECTED);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(EXPECTED + 1);
  localparam logic [3:0]       LOCK_C    = 4'(LOCK_COUNT);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic [3:0]       mc;
  logic [3:0]       mc_next;
  logic             match;

  always_comb begin
    match   = (cnt == EXP_C) && !sat;
    mc_next = 4'd0;
    if (match) begin
      mc_next = (mc >= LOCK_C) ? LOCK_C : mc + 4'd1;
    end
  end

  always_ff @(posedge Pixelclock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sat          <= 1'b0;
      mc           <= 4'd0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      locked       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state <= MEASURE;
            cnt   <= CNT_W'(1);
            sat   <= 1'b0;
          end
        end
        default: begin
          if (tick) begin
            period       <= cnt;
            overflow     <= sat;
            period_valid <= 1'b1;
            cnt          <= CNT_W'(1);
            sat          <= 1'b0;
            mc           <= mc_next;
            locked       <= (mc_next == LOCK_C);
          end else begin
            // sat marks the count as clipped as soon as it reaches all-ones
            if (cnt != CNT_MAX) begin
              cnt <= cnt + CNT_W'(1);
            end
            if (cnt >= CNT_MAX - CNT_W'(1)) begin
              sat <= 1'b1;
            end
            if (cnt == TIMEOUT_C) begin
              mc     <= 4'd0;
              locked <= 1'b0;
            end
          end
        end
      endcase
    end
  end

`ifdef PERIOD_MINMAX_EN
  always_ff @(posedge Pixelclock) begin
    if (reset) begin
      min_period <= '1;
      max_period <= '0;
    end else if (state == MEASURE && tick) begin
      if (sat) begin
        max_period <= '1;
      end else begin
        if (cnt < min_period) min_period <= cnt;
        if (cnt > max_period) max_period <= cnt;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tick_period_monitor.sv
`default_nettype none
// tb_tick_period_monitor: directed tick patterns; expected pulses are queued
// by the stimulus and checked by per-instance monitors.
module tb_tick_period_monitor;

  typedef struct packed {
    logic [15:0] per;
    logic        ovf;
    logic        lck;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_m = 1'b1, tick_m = 1'b0;
  logic [15:0] period_m;
  logic        valid_m, ovf_m, locked_m;
  logic        reset_s = 1'b1, tick_s = 1'b0;
  logic [7:0]  period_s;
  logic        valid_s, ovf_s, locked_s;
`ifdef PERIOD_MINMAX_EN
  logic [15:0] min_m, max_m;
  logic [7:0]  min_s, max_s;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q_m[$];
  exp_t q_s[$];
  exp_t e_m, e_s;

  tick_period_monitor dut_m (
    .Pixelclock   (clk),
    .reset        (reset_m),
    .tick         (tick_m),
    .period       (period_m),
    .period_valid (valid_m),
    .overflow     (ovf_m),
    .locked       (locked_m)
`ifdef PERIOD_MINMAX_EN
    ,
    .min_period   (min_m),
    .max_period   (max_m)
`endif
  );

  // small instance makes timeout and saturation reachable in a few hundred cycles
  tick_period_monitor #(.EXPECTED(10), .CNT_W(8), .LOCK_COUNT(2)) dut_s (
    .Pixelclock   (clk),
    .reset        (reset_s),
    .tick         (tick_s),
    .period       (period_s),
    .period_valid (valid_s),
    .overflow     (ovf_s),
    .locked       (locked_s)
`ifdef PERIOD_MINMAX_EN
    ,
    .min_period   (min_s),
    .max_period   (max_s)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valid_m) begin
      if (q_m.size() == 0) begin
        check("m_spurious_valid", 32'(valid_m), 32'd0);
      end else begin
        e_m = q_m.pop_front();
        check("m_period", 32'(period_m), 32'(e_m.per));
        check("m_overflow", 32'(ovf_m), 32'(e_m.ovf));
        check("m_locked", 32'(locked_m), 32'(e_m.lck));
      end
    end
  end

  always @(negedge clk) begin
    if (valid_s) begin
      if (q_s.size() == 0) begin
        check("s_spurious_valid", 32'(valid_s), 32'd0);
      end else begin
        e_s = q_s.pop_front();
        check("s_period", 32'(period_s), 32'(e_s.per));
        check("s_overflow", 32'(ovf_s), 32'(e_s.ovf));
        check("s_locked", 32'(locked_s), 32'(e_s.lck));
      end
    end
  end

  task automatic push_m(input int p, input logic o, input logic l);
    q_m.push_back('{per: 16'(p), ovf: o, lck: l});
  endtask
  task automatic push_s(input int p, input logic o, input logic l);
    q_s.push_back('{per: 16'(p), ovf: o, lck: l});
  endtask

  task automatic step_m(input logic t);
    @(negedge clk);
    tick_m = t;
  endtask
  task automatic gap_m(input int n);
    repeat (n - 1) step_m(1'b0);
    step_m(1'b1);
  endtask
  task automatic reset_pulse_m();
    @(negedge clk);
    reset_m = 1'b1;
    tick_m  = 1'b0;
    @(negedge clk);
    reset_m = 1'b0;
  endtask

  task automatic step_s(input logic t);
    @(negedge clk);
    tick_s = t;
  endtask
  task automatic gap_s(input int n);
    repeat (n - 1) step_s(1'b0);
    step_s(1'b1);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_m = 1'b0;
    check("rst_period", 32'(period_m), 32'd0);
    check("rst_valid", 32'(valid_m), 32'd0);
    check("rst_overflow", 32'(ovf_m), 32'd0);
    check("rst_locked", 32'(locked_m), 32'd0);
`ifdef PERIOD_MINMAX_EN
    check("rst_min", 32'(min_m), 32'hFFFF);
    check("rst_max", 32'(max_m), 32'd0);
`endif

    // tick held high for five cycles: four back-to-back periods of 1
    repeat (4) push_m(1, 1'b0, 1'b0);
    repeat (5) step_m(1'b1);
    repeat (4) step_m(1'b0);
    check("held_locked", 32'(locked_m), 32'd0);

    // six ticks at 6250 lock on the fourth pulse; a 6249 interval unlocks
    reset_pulse_m();
    for (int i = 1; i <= 5; i++) push_m(6250, 1'b0, i >= 4);
    step_m(1'b1);
    repeat (5) gap_m(6250);
    push_m(6249, 1'b0, 1'b0);
    gap_m(6249);
    for (int i = 1; i <= 4; i++) push_m(6250, 1'b0, i == 4);
    repeat (4) gap_m(6250);
    repeat (3) step_m(1'b0);
    check("relock_locked", 32'(locked_m), 32'd1);
`ifdef PERIOD_MINMAX_EN
    check("m_min", 32'(min_m), 32'd6249);
    check("m_max", 32'(max_m), 32'd6250);
`endif

    // reset mid-measurement: first tick afterwards only starts a count
    reset_pulse_m();
    step_m(1'b1);
    repeat (2999) step_m(1'b0);
    reset_pulse_m();
    gap_m(100);
    push_m(6250, 1'b0, 1'b0);
    gap_m(6250);
    repeat (3) step_m(1'b0);
    check("rstmid_locked", 32'(locked_m), 32'd0);

    // small instance: lock, timeout, saturation, tick at the timeout edge
    @(negedge clk);
    reset_s = 1'b0;
    push_s(10, 1'b0, 1'b0);
    push_s(10, 1'b0, 1'b1);
    step_s(1'b1);
    repeat (2) gap_s(10);
    repeat (11) step_s(1'b0);
    check("s_pre_timeout_locked", 32'(locked_s), 32'd1);
    step_s(1'b0);
    check("s_timeout_locked", 32'(locked_s), 32'd0);
    push_s(255, 1'b1, 1'b0);
    repeat (288) step_s(1'b0);
    step_s(1'b1);
    push_s(10, 1'b0, 1'b0);
    push_s(10, 1'b0, 1'b1);
    push_s(11, 1'b0, 1'b0);
    gap_s(10);
    gap_s(10);
    gap_s(11);
    repeat (3) step_s(1'b0);
    check("s_final_locked", 32'(locked_s), 32'd0);
`ifdef PERIOD_MINMAX_EN
    check("s_min", 32'(min_s), 32'd10);
    check("s_max", 32'(max_s), 32'd255);
`endif

    repeat (2) @(negedge clk);
    check("m_queue_left", 32'(q_m.size()), 32'd0);
    check("s_queue_left", 32'(q_s.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
